// File: rtl/snn_pkg.sv
// Shared SNN definitions: decoder controller states and a saturating increment
// used by several spike-processing blocks.
package snn_pkg;

  typedef enum logic [0:0] {StIdle, StAccum} decoder_state_e;

  // Operands are zero-extended to 32 bits; callers truncate back to their width.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_value);
    return (value >= max_value) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/spike_rate_decoder_if.sv
// Result channel of the spike rate decoder: decoded fields plus valid/ready.
interface spike_rate_decoder_if #(
  parameter int unsigned COUNT_WIDTH = 8,
  parameter int unsigned LAT_WIDTH   = 4
);

  logic [COUNT_WIDTH-1:0] rate_out;
  logic [LAT_WIDTH-1:0]   first_latency;
  logic                   no_spike;
  logic                   result_valid;
  logic                   result_ready;

  modport master (
    output rate_out,
    output first_latency,
    output no_spike,
    output result_valid,
    input  result_ready
  );

  modport slave (
    input  rate_out,
    input  first_latency,
    input  no_spike,
    input  result_valid,
    output result_ready
  );

endinterface

// File: rtl/spike_result_buffer.sv
// One-entry result holding register with valid/ready handshake and a sticky
// overrun flag for loads that arrive while an unaccepted result is held.
module spike_result_buffer #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  ready_i,
  input  logic                  clear_overrun_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  overrun_o
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  overrun_q, overrun_d;
  logic                  overrun_set;

  always_comb begin
    valid_d     = valid_q;
    data_d      = data_q;
    overrun_set = 1'b0;
    if (load_i) begin
      // A same-cycle transfer frees the slot, so the new result still fits.
      if (!valid_q || ready_i) begin
        valid_d = 1'b1;
        data_d  = data_i;
      end else begin
        overrun_set = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    overrun_d = overrun_set | (overrun_q & ~clear_overrun_i);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q   <= 1'b0;
      data_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
    end
  end

  assign valid_o   = valid_q;
  assign data_o    = data_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/spike_rate_decoder.sv
// Decodes a spike train into per-window rate (saturating count) and latency
// (index of first spike) codes, published through a one-entry result buffer.
module spike_rate_decoder
  import snn_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES = 16,
  parameter int unsigned COUNT_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 spike_in,
  input  logic                 clear_overrun,
  output logic                 overrun,
  spike_rate_decoder_if.master res
);

  localparam int unsigned LAT_WIDTH = $clog2(WINDOW_CYCLES);
  localparam int unsigned DataWidth = COUNT_WIDTH + LAT_WIDTH + 1;
  localparam logic [31:0] CountMax  = (32'd1 << COUNT_WIDTH) - 32'd1;
  localparam logic [LAT_WIDTH-1:0] LastIdx = LAT_WIDTH'(WINDOW_CYCLES - 1);

  decoder_state_e         state_q, state_d;
  logic [LAT_WIDTH-1:0]   win_cnt_q, win_cnt_d;
  logic [COUNT_WIDTH-1:0] spk_cnt_q, spk_cnt_d;
  logic [LAT_WIDTH-1:0]   lat_q, lat_d;
  logic                   seen_q, seen_d;

  logic [COUNT_WIDTH-1:0] spk_upd;
  logic [LAT_WIDTH-1:0]   lat_upd;
  logic                   seen_upd;
  logic                   load;
  logic [DataWidth-1:0]   load_data;
  logic [DataWidth-1:0]   held_data;

  always_comb begin
    state_d   = state_q;
    win_cnt_d = '0;
    spk_cnt_d = '0;
    lat_d     = '0;
    seen_d    = 1'b0;
    load      = 1'b0;

    // Counter values including the current sample; the final cycle publishes these.
    spk_upd  = spike_in ? COUNT_WIDTH'(sat_inc(32'(spk_cnt_q), CountMax)) : spk_cnt_q;
    lat_upd  = (spike_in && !seen_q) ? win_cnt_q : lat_q;
    seen_upd = seen_q | spike_in;
    load_data = {spk_upd, (seen_upd ? lat_upd : LastIdx), ~seen_upd};

    unique case (state_q)
      StIdle: begin
        if (enable) state_d = StAccum;
      end
      StAccum: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (win_cnt_q == LastIdx) begin
          load = 1'b1;
        end else begin
          win_cnt_d = win_cnt_q + LAT_WIDTH'(1);
          spk_cnt_d = spk_upd;
          lat_d     = lat_upd;
          seen_d    = seen_upd;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      win_cnt_q <= '0;
      spk_cnt_q <= '0;
      lat_q     <= '0;
      seen_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      spk_cnt_q <= spk_cnt_d;
      lat_q     <= lat_d;
      seen_q    <= seen_d;
    end
  end

  spike_result_buffer #(
    .DATA_WIDTH(DataWidth)
  ) u_result_buffer (
    .clk             (clk),
    .reset_n         (reset_n),
    .load_i          (load),
    .data_i          (load_data),
    .ready_i         (res.result_ready),
    .clear_overrun_i (clear_overrun),
    .valid_o         (res.result_valid),
    .data_o          (held_data),
    .overrun_o       (overrun)
  );

  assign res.rate_out      = held_data[DataWidth-1 -: COUNT_WIDTH];
  assign res.first_latency = held_data[LAT_WIDTH:1];
  assign res.no_spike      = held_data[0];

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: two instances (8-bit and 3-bit counts) share
// stimulus and are checked every cycle against a window-level reference model.
module tb_spike_rate_decoder;

  localparam int W = 16;

  logic clk = 1'b0;
  logic reset_n, enable, spike_in, rdy, clear_overrun;
  logic ov8, ov3;

  always #5 clk = ~clk;

  spike_rate_decoder_if #(.COUNT_WIDTH(8), .LAT_WIDTH(4)) if8 ();
  spike_rate_decoder_if #(.COUNT_WIDTH(3), .LAT_WIDTH(4)) if3 ();

  assign if8.result_ready = rdy;
  assign if3.result_ready = rdy;

  spike_rate_decoder #(.WINDOW_CYCLES(W), .COUNT_WIDTH(8)) u_dut8 (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .spike_in      (spike_in),
    .clear_overrun (clear_overrun),
    .overrun       (ov8),
    .res           (if8)
  );

  spike_rate_decoder #(.WINDOW_CYCLES(W), .COUNT_WIDTH(3)) u_dut3 (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .spike_in      (spike_in),
    .clear_overrun (clear_overrun),
    .overrun       (ov3),
    .res           (if3)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: samples of the open window kept as a list, results
  // computed from the whole list when the window fills.
  bit         m_running;
  bit         win[$];
  int         m_cnt;
  logic [3:0] m_lat;
  bit         m_ns, m_v, m_ov;

  function automatic void model_reset();
    m_running = 0;
    win.delete();
    m_cnt = 0;
    m_lat = '0;
    m_ns  = 0;
    m_v   = 0;
    m_ov  = 0;
  endfunction

  function automatic void model_edge(bit en, bit spk, bit rd, bit clr);
    bit done = 0;
    bit set  = 0;
    int c    = 0;
    int f    = W - 1;
    bit found = 0;
    if (!m_running) begin
      if (en) m_running = 1;
      win.delete();
    end else if (!en) begin
      m_running = 0;
      win.delete();
    end else begin
      win.push_back(spk);
      if (win.size() == W) done = 1;
    end
    if (done) begin
      if (!m_v || rd) begin
        for (int i = 0; i < W; i++) begin
          if (win[i]) begin
            c++;
            if (!found) begin
              f = i;
              found = 1;
            end
          end
        end
        m_cnt = c;
        m_lat = 4'(f);
        m_ns  = (c == 0);
        m_v   = 1;
      end else begin
        set = 1;
      end
      win.delete();
    end else if (m_v && rd) begin
      m_v = 0;
    end
    m_ov = set | (m_ov & !clr);
  endfunction

  task automatic check(input string tag);
    logic [14:0] a8, e8;
    logic [9:0]  a3, e3;
    int r8, r3;
    r8 = (m_cnt > 255) ? 255 : m_cnt;
    r3 = (m_cnt > 7) ? 7 : m_cnt;
    e8 = {r8[7:0], m_lat, m_ns, m_v, m_ov};
    e3 = {r3[2:0], m_lat, m_ns, m_v, m_ov};
    a8 = {if8.rate_out, if8.first_latency, if8.no_spike, if8.result_valid, ov8};
    a3 = {if3.rate_out, if3.first_latency, if3.no_spike, if3.result_valid, ov3};
    checks++;
    assert (a8 === e8) else begin
      errors++;
      $error("FAIL %s dut8 {rate,lat,ns,v,ov} got %h expected %h", tag, a8, e8);
    end
    checks++;
    assert (a3 === e3) else begin
      errors++;
      $error("FAIL %s dut3 {rate,lat,ns,v,ov} got %h expected %h", tag, a3, e3);
    end
  endtask

  task automatic cyc(input bit en, input bit spk, input bit rd, input bit clr,
                     input string tag);
    enable        = en;
    spike_in      = spk;
    rdy           = rd;
    clear_overrun = clr;
    @(posedge clk);
    model_edge(en, spk, rd, clr);
    #1;
    check(tag);
  endtask

  initial begin
    int dens;
    reset_n = 1'b0;
    enable = 1'b0;
    spike_in = 1'b0;
    rdy = 1'b0;
    clear_overrun = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset");
    reset_n = 1'b1;

    // Spikes on samples 2, 6, 10, 14 with consumer always ready.
    cyc(1, 0, 1, 0, "t1_enable");
    for (int k = 0; k < W; k++) cyc(1, (k % 4) == 2, 1, 0, "t1_rate");
    // Silent window, back-to-back.
    for (int k = 0; k < W; k++) cyc(1, 0, 1, 0, "t2_silent");
    // All-spike window: 3-bit instance saturates.
    for (int k = 0; k < W; k++) cyc(1, 1, 1, 0, "t3_sat");

    // Backpressure across two windows, then clear, then ready on completion edge.
    for (int k = 0; k < 2 * W; k++) cyc(1, $urandom_range(0, 1) == 1, 0, 0, "t4_hold");
    cyc(1, 1, 0, 1, "t4_clear");
    for (int k = 1; k < W - 1; k++) cyc(1, $urandom_range(0, 1) == 1, 0, 0, "t4_wait");
    cyc(1, 0, 1, 0, "t4_ready_on_done");
    cyc(1, 0, 1, 0, "t4_accept");

    // Enable drop at sample 9, then a fresh window.
    cyc(0, 0, 1, 0, "t5_idle");
    cyc(0, 0, 1, 0, "t5_idle");
    cyc(1, 0, 1, 0, "t5_enable");
    for (int k = 0; k < 9; k++) cyc(1, 1, 1, 0, "t5_partial");
    cyc(0, 1, 1, 0, "t5_drop");
    for (int k = 0; k < 3; k++) cyc(0, 1, 1, 0, "t5_off");
    cyc(1, 0, 1, 0, "t5_reenable");
    for (int k = 0; k < W; k++) cyc(1, (k == 11) || (k == 13), 1, 0, "t5_fresh");

    // Randomised traffic with varying spike density.
    dens = 50;
    for (int k = 0; k < 480; k++) begin
      if ((k % 64) == 0) dens = $urandom_range(0, 100);
      cyc($urandom_range(0, 39) != 0, $urandom_range(0, 99) < dens,
          $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, "rand");
    end

    // Asynchronous reset mid-window while a result is held.
    cyc(1, 0, 0, 0, "t6_enable");
    for (int k = 0; k < W + 5; k++) cyc(1, $urandom_range(0, 1) == 1, 0, 0, "t6_fill");
    #2;
    reset_n = 1'b0;
    enable = 1'b0;
    #1;
    model_reset();
    check("t6_async_reset");
    @(posedge clk);
    #1;
    check("t6_reset_held");
    reset_n = 1'b1;
    cyc(1, 0, 0, 0, "t6_enable2");
    for (int k = 0; k < W; k++) cyc(1, k >= 7, 0, 0, "t6_first");
    cyc(1, 0, 1, 0, "t6_accept");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
